// File: rtl/up_mem_responder_if.sv
// Multiplexed address/data bus between the controller/datapath (master)
// and the memory responder (slave).
interface up_mem_responder_if;
  logic       ale;
  logic       mem_we;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       mem_re;
  logic       busy;
  logic       wp_err;

  modport master (
    output ale, mem_we, bus_in,
    input  bus_out, bus_oe, mem_re, busy, wp_err
  );

  modport slave (
    input  ale, mem_we, bus_in,
    output bus_out, bus_oe, mem_re, busy, wp_err
  );
endinterface

// File: rtl/up_mem_responder.sv
// ALE-framed memory responder with a 2**ADDR_W x 8 RAM and programmable read wait states.
// Optional write protection above WP_BASE is enabled by defining UP_MEM_WRITE_PROTECT_EN.
module up_mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [7:0]  WP_BASE     = 8'h80
) (
  input  logic                clk,
  input  logic                nRst,
  up_mem_responder_if.slave   bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  localparam logic [3:0] WS_RELOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [7:0]        mem_q [DEPTH];
  logic              mem_wr;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [7:0]        bus_out_q, bus_out_d;
  logic              bus_oe_q, bus_oe_d;
  logic              mem_re_q, mem_re_d;
  logic              busy_q, busy_d;
  logic              wp_err_q, wp_err_d;
  logic              load_data;
  logic              wp_hit;

`ifdef UP_MEM_WRITE_PROTECT_EN
  localparam int unsigned WP_BASE_I = 32'(WP_BASE);
  assign wp_hit = (32'(addr_q) >= WP_BASE_I);
`else
  logic [7:0] unused_wp_base;
  assign unused_wp_base = WP_BASE;
  assign wp_hit         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wait_cnt_d = wait_cnt_q;
    bus_out_d  = bus_out_q;
    bus_oe_d   = 1'b0;
    mem_re_d   = 1'b0;
    wp_err_d   = 1'b0;
    mem_wr     = 1'b0;
    load_data  = 1'b0;

    // A new ALE in any state starts a fresh transaction and outranks mem_we.
    if (bus.ale) begin
      addr_d  = bus.bus_in[ADDR_W-1:0];
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ARMED: begin
          if (bus.mem_we) begin
            if (wp_hit) wp_err_d = 1'b1;
            else        mem_wr   = 1'b1;
            state_d = S_IDLE;
          end else if (WAIT_STATES == 0) begin
            load_data = 1'b1;
            state_d   = S_DATA;
          end else begin
            wait_cnt_d = WS_RELOAD;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            load_data = 1'b1;
            state_d   = S_DATA;
          end else begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end
        end
        S_DATA:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Read data and strobes are registered on entry to DATA so they line up with that state.
    if (load_data) begin
      bus_out_d = mem_q[addr_q];
      bus_oe_d  = 1'b1;
      mem_re_d  = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wait_cnt_q <= '0;
      bus_out_q  <= '0;
      bus_oe_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      busy_q     <= 1'b0;
      wp_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wait_cnt_q <= wait_cnt_d;
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      mem_re_q   <= mem_re_d;
      busy_q     <= busy_d;
      wp_err_q   <= wp_err_d;
    end
  end

  // RAM contents survive reset and are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[addr_q] <= bus.bus_in;
  end

  assign bus.bus_out = bus_out_q;
  assign bus.bus_oe  = bus_oe_q;
  assign bus.mem_re  = mem_re_q;
  assign bus.busy    = busy_q;
  assign bus.wp_err  = wp_err_q;

endmodule

// File: tb/tb_up_mem_responder.sv
// Directed bench for up_mem_responder: table-driven vectors on a zero-wait-state
// instance plus hand-written wait-state, abort and reset sequences on a 3-wait-state instance.
module tb_up_mem_responder;

  logic clk  = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  up_mem_responder_if b0();
  up_mem_responder_if b3();

  up_mem_responder #(.ADDR_W(8), .WAIT_STATES(0), .WP_BASE(8'h80)) dut0 (
    .clk(clk), .nRst(nRst), .bus(b0)
  );
  up_mem_responder #(.ADDR_W(8), .WAIT_STATES(3), .WP_BASE(8'h80)) dut3 (
    .clk(clk), .nRst(nRst), .bus(b3)
  );

`ifdef UP_MEM_WRITE_PROTECT_EN
  localparam logic WP = 1'b1;
`else
  localparam logic WP = 1'b0;
`endif

  typedef struct {
    logic       ale;
    logic       we;
    logic [7:0] din;
    logic       re;
    logic [7:0] dout;
    logic       busy;
    logic       wp;
    logic       chk_out;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic a, logic w, logic [7:0] d, logic re,
                              logic [7:0] dout, logic busy, logic wp, logic chk);
    vec_t r;
    r.ale = a; r.we = w; r.din = d; r.re = re;
    r.dout = dout; r.busy = busy; r.wp = wp; r.chk_out = chk;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc0(input logic a, input logic w, input logic [7:0] d);
    @(negedge clk);
    b0.ale = a; b0.mem_we = w; b0.bus_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc3(input logic a, input logic w, input logic [7:0] d);
    @(negedge clk);
    b3.ale = a; b3.mem_we = w; b3.bus_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr3(input logic [7:0] a, input logic [7:0] d);
    cyc3(1'b1, 1'b0, a);
    cyc3(1'b0, 1'b1, d);
  endtask

  // Read on the 3-wait-state instance: first mem_re must come on the 5th edge
  // counting the ALE edge, with busy high throughout and a single-cycle pulse.
  task automatic rd3(input logic [7:0] a, input logic [7:0] exp, input string name);
    int         k_re    = 0;
    logic       busy_ok = 1'b1;
    logic [7:0] got     = 8'h00;
    logic       oe      = 1'b0;
    cyc3(1'b1, 1'b0, a);
    if (!b3.busy) busy_ok = 1'b0;
    if (b3.mem_re) begin k_re = 1; got = b3.bus_out; oe = b3.bus_oe; end
    for (int k = 2; k <= 12 && k_re == 0; k++) begin
      cyc3(1'b0, 1'b0, 8'h00);
      if (!b3.busy) busy_ok = 1'b0;
      if (b3.mem_re) begin k_re = k; got = b3.bus_out; oe = b3.bus_oe; end
    end
    check({name, ".latency"}, 8'(k_re), 8'd5);
    check({name, ".busy"}, {7'd0, busy_ok}, 8'd1);
    check({name, ".bus_oe"}, {7'd0, oe}, 8'd1);
    check({name, ".bus_out"}, got, exp);
    cyc3(1'b0, 1'b0, 8'h00);
    check({name, ".pulse_end"}, {7'd0, b3.mem_re}, 8'd0);
    check({name, ".idle"}, {7'd0, b3.busy}, 8'd0);
  endtask

  initial begin
    b0.ale = 1'b0; b0.mem_we = 1'b0; b0.bus_in = 8'h00;
    b3.ale = 1'b0; b3.mem_we = 1'b0; b3.bus_in = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.mem_re",  {7'd0, b0.mem_re}, 8'd0);
    check("rst.bus_oe",  {7'd0, b0.bus_oe}, 8'd0);
    check("rst.busy",    {7'd0, b0.busy},   8'd0);
    check("rst.wp_err",  {7'd0, b0.wp_err}, 8'd0);
    check("rst.bus_out", b0.bus_out,        8'h00);
    check("rst3.busy",   {7'd0, b3.busy},   8'd0);
    @(negedge clk);
    nRst = 1'b1;

    //           ale we  din    re dout   busy wp  chk
    tbl.push_back(mk(1, 0, 8'h12, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h12, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hA5, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h20, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h77, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h20, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h77, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hEE, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h20, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h77, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h12, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 1, 8'h20, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h77, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h12, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hA5, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h12, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hA5, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'h20, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h77, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h90, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h55, 0, 8'h00, 0, WP, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h90, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h55, 1, 0, !WP));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h7F, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h55, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h7F, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h55, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0));

    foreach (tbl[i]) begin
      cyc0(tbl[i].ale, tbl[i].we, tbl[i].din);
      check($sformatf("vec%0d.mem_re", i), {7'd0, b0.mem_re}, {7'd0, tbl[i].re});
      check($sformatf("vec%0d.bus_oe", i), {7'd0, b0.bus_oe}, {7'd0, tbl[i].re});
      check($sformatf("vec%0d.busy", i),   {7'd0, b0.busy},   {7'd0, tbl[i].busy});
      check($sformatf("vec%0d.wp_err", i), {7'd0, b0.wp_err}, {7'd0, tbl[i].wp});
      if (tbl[i].chk_out)
        check($sformatf("vec%0d.bus_out", i), b0.bus_out, tbl[i].dout);
    end

    // Wait states
    wr3(8'h40, 8'h3C);
    rd3(8'h40, 8'h3C, "ws3_rd40");

    // Abort a read of 0x40 during WAIT with a new ALE to 0x41
    wr3(8'h41, 8'h9D);
    cyc3(1'b1, 1'b0, 8'h40);
    check("abort.re_armed", {7'd0, b3.mem_re}, 8'd0);
    cyc3(1'b0, 1'b0, 8'h00);
    check("abort.re_wait1", {7'd0, b3.mem_re}, 8'd0);
    cyc3(1'b0, 1'b0, 8'h00);
    check("abort.re_wait2", {7'd0, b3.mem_re}, 8'd0);
    check("abort.busy",     {7'd0, b3.busy},   8'd1);
    rd3(8'h41, 8'h9D, "abort_rd41");

    // Asynchronous reset during WAIT
    cyc3(1'b1, 1'b0, 8'h40);
    cyc3(1'b0, 1'b0, 8'h00);
    check("rstmid.busy_before", {7'd0, b3.busy}, 8'd1);
    #2 nRst = 1'b0;
    #1;
    check("rstmid.mem_re", {7'd0, b3.mem_re}, 8'd0);
    check("rstmid.bus_oe", {7'd0, b3.bus_oe}, 8'd0);
    check("rstmid.busy",   {7'd0, b3.busy},   8'd0);
    check("rstmid.wp_err", {7'd0, b3.wp_err}, 8'd0);
    @(posedge clk);
    @(negedge clk);
    nRst = 1'b1;
    rd3(8'h40, 8'h3C, "post_rst_rd40");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/up_mem_responder.md
Name: up_mem_responder

Overview:
- Memory-side responder for the microprocessor's multiplexed address/data bus. The controller issues ALE-framed reads and writes; this block services them.
- Latches the address on `ale` and holds a DEPTH x 8 internal RAM.
- Accepts a write when `mem_we` is high in the cycle after `ale`.
- Otherwise returns read data after a programmable number of wait states, flagged by a one-cycle `mem_re` pulse.
- Sits between the controller/datapath bus and system memory.

Parameters:
- ADDR_W, 8, address width; RAM depth is 2**ADDR_W bytes.
- WAIT_STATES, 0, extra cycles inserted before read data is returned; legal range 0..15.
- WP_BASE, 8'h80, first write-protected address; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- nRst  input  1  asynchronous active-low reset.
- ale  input  1  address latch enable; `bus_in` carries the address this cycle.
- mem_we  input  1  write strobe; `bus_in` carries write data this cycle.
- bus_in  input  8  address/data driven by the datapath.
- bus_out  output  8  read data.
- bus_oe  output  1  `bus_out` valid; the datapath muxes it onto the bus.
- mem_re  output  1  one-cycle read-data-valid pulse to the controller.
- busy  output  1  high in any state other than IDLE.
- wp_err  output  1  write-protect violation pulse; tied 0 when the feature is absent.

Behaviour:
- Reset: one cycle is a single `clk` period.
  - State goes to IDLE. `addr_q`, `wait_cnt`, `bus_out`, `bus_oe`, `mem_re`, `busy` and `wp_err` all go to 0.
  - RAM contents are not reset and are undefined until written.
- States: IDLE, ARMED, WAIT, DATA.
- IDLE:
  - If `ale`: `addr_q <= bus_in[ADDR_W-1:0]`, then go to ARMED.
  - If `mem_we` arrives without `ale`, it is ignored.
- ARMED (the cycle after `ale`):
  - If `mem_we`: `mem[addr_q] <= bus_in`, then go to IDLE. No `mem_re`.
  - If not `mem_we` and WAIT_STATES==0: go to DATA.
  - If not `mem_we` and WAIT_STATES>0: `wait_cnt <= WAIT_STATES-1`, then go to WAIT.
- WAIT:
  - Decrement `wait_cnt`.
  - Go to DATA in the cycle after `wait_cnt`==0.
  - `mem_we` is ignored in this state.
- DATA:
  - `bus_out` = `mem[addr_q]`, registered on entry. `bus_oe`=1 and `mem_re`=1 for exactly one cycle, then go to IDLE.
- Read latency:
  - `mem_re` is high in cycle `ale`+1+WAIT_STATES+1 when counting registered outputs; with WAIT_STATES=0 that is 2 cycles after the `ale` cycle.
  - Implementation: `bus_out`/`bus_oe`/`mem_re` are registered outputs set on the ARMED→DATA or WAIT→DATA transition.
- `ale` outside IDLE:
  - In ARMED, WAIT or DATA, a new `ale` aborts the transaction in progress. `addr_q` is reloaded and the state goes to ARMED.
  - If the abort happens in DATA, the current `mem_re` pulse still completes that cycle.
  - In ARMED, `ale` takes priority over `mem_we`; no write occurs.
- Same cycle in IDLE: `ale` and `mem_we` together → `ale` wins, no write.
- Address wrap: `addr_q` is truncated to ADDR_W; there is no auto-increment.
- `busy` = (state != IDLE), registered.
- `bus_out` holds its last value when `bus_oe`=0. The bench checks it only while `bus_oe`=1.
- Reset mid-transaction: an asynchronous drop to IDLE. A pending write whose `mem_we` was not yet sampled is lost; RAM is otherwise unchanged.

Optional Feature:
- Macro UP_MEM_WRITE_PROTECT_EN.
- Defined:
  - A write in ARMED with `addr_q` >= WP_BASE is suppressed and RAM is unchanged.
  - `wp_err` pulses high for one cycle, the cycle after the write attempt, and the state returns to IDLE.
  - Reads are unaffected.
- Undefined: all addresses are writable and `wp_err` is constant 0.

Test Plan:
- Write then read, WAIT_STATES=0: `ale` with `bus_in`=8'h12, next cycle `mem_we` with data 8'hA5; then `ale` 8'h12, no `mem_we` → `mem_re`=1, `bus_oe`=1, `bus_out`=8'hA5 exactly two cycles after the second `ale`, for one cycle only.
- Wait states, WAIT_STATES=3: write 8'h3C to 8'h40, then read 8'h40 → `mem_re` 5 cycles after `ale`, `busy`=1 throughout, `bus_out`=8'h3C.
- Abort, WAIT_STATES=3: read 8'h40, then `ale` 8'h41 during WAIT → no `mem_re` for 8'h40; a single `mem_re` returns `mem[8'h41]` 5 cycles after the second `ale`.
- Priority: `ale` and `mem_we` together in IDLE with `bus_in`=8'h20 → only the address is latched and no RAM write (read 8'h20 afterwards returns its prior value). `mem_we` in IDLE alone → RAM unchanged.
- Reset mid-read: drop `nRst` during WAIT → `mem_re`, `bus_oe`, `busy` and `wp_err` go 0 immediately. After release, a fresh read of a previously written address returns the correct data.
- With UP_MEM_WRITE_PROTECT_EN, WP_BASE=8'h80: write 8'h55 to 8'h90 → `wp_err` pulses once and reading 8'h90 returns the old value. Write 8'h55 to 8'h7F → succeeds and `wp_err` stays 0.
